serial_subtractor: RTL and testbench

//  Multi-cycle, digit-serial unsigned subtractor computing diff = a - b over WIDTH bits.

---
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b, DIGIT bits per cycle, LSB first.
// Optional macro SUB_OVERFLOW_EN adds a two's-complement overflow output.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             borrow_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [DIGIT-1:0] a_digit;
    logic [DIGIT-1:0] b_digit;
    logic [DIGIT:0]   digit_res;
    logic             last_digit;

    // One digit of the ripple: the extra top bit of the DIGIT+1 wide result is the borrow out.
    always_comb begin
        a_digit    = a_reg[int'(count) * DIGIT +: DIGIT];
        b_digit    = b_reg[int'(count) * DIGIT +: DIGIT];
        digit_res  = {1'b0, a_digit} - {1'b0, b_digit} - {{DIGIT{1'b0}}, borrow_reg};
        last_digit = (count == LAST);
    end

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            borrow_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            diff       <= '0;
            borrow     <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        count      <= '0;
                        borrow_reg <= 1'b0;
                        busy       <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    diff[int'(count) * DIGIT +: DIGIT] <= digit_res[DIGIT-1:0];
                    borrow_reg <= digit_res[DIGIT];
                    if (last_digit) begin
                        count     <= '0;
                        borrow    <= digit_res[DIGIT];
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SUB_OVERFLOW_EN
                        // The final digit's top bit is the result sign bit.
                        overflow  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                                     (digit_res[DIGIT-1] != a_reg[WIDTH-1]);
`endif
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
`ifdef SUB_OVERFLOW_EN
                        overflow  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (DIGIT=1 and DIGIT=4 instances).
// Overflow checks and the randomized run are built only with SUB_OVERFLOW_EN.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_ready = 1'b0;
    logic         in_valid1 = 1'b0;
    logic         in_valid4 = 1'b0;

    logic         in_ready1, out_valid1, borrow1, busy1;
    logic [W-1:0] diff1;
    logic         in_ready4, out_valid4, borrow4, busy4;
    logic [W-1:0] diff4;
`ifdef SUB_OVERFLOW_EN
    logic         overflow1, overflow4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .diff(diff1), .borrow(borrow1), .busy(busy1)
`ifdef SUB_OVERFLOW_EN
        , .overflow(overflow1)
`endif
    );

    serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
        .diff(diff4), .borrow(borrow4), .busy(busy4)
`ifdef SUB_OVERFLOW_EN
        , .overflow(overflow4)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Input handshake on the DIGIT=1 instance; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
        a         = av;
        b         = bv;
        in_valid1 = 1'b1;
        checkOutput("in_ready_idle", 32'(in_ready1), 32'd1);
        @(negedge clk);
        in_valid1 = 1'b0;
        a         = ~av;
        b         = ~bv;
        checkOutput("busy_after_accept", 32'(busy1), 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] exp_diff, input logic exp_borrow);
        int cycles;
        applyStimulus(av, bv);
        cycles = 0;
        while (out_valid1 !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "/latency"}, 32'(cycles), 32'd8);
        checkOutput({tag, "/diff"}, 32'(diff1), 32'(exp_diff));
        checkOutput({tag, "/borrow"}, 32'(borrow1), 32'(exp_borrow));
        checkOutput({tag, "/in_ready_done"}, 32'(in_ready1), 32'd0);
`ifdef SUB_OVERFLOW_EN
        checkOutput({tag, "/overflow"}, 32'(overflow1),
                    32'((av[W-1] != bv[W-1]) && (exp_diff[W-1] != av[W-1])));
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "/out_valid_drop"}, 32'(out_valid1), 32'd0);
        checkOutput({tag, "/in_ready_back"}, 32'(in_ready1), 32'd1);
    endtask

    task automatic runOp4(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_diff, input logic exp_borrow);
        a         = av;
        b         = bv;
        in_valid4 = 1'b1;
        checkOutput({tag, "/in_ready"}, 32'(in_ready4), 32'd1);
        @(negedge clk);
        in_valid4 = 1'b0;
        checkOutput({tag, "/busy"}, 32'(busy4), 32'd1);
        checkOutput({tag, "/out_valid_t0"}, 32'(out_valid4), 32'd0);
        @(negedge clk);
        checkOutput({tag, "/out_valid_t1"}, 32'(out_valid4), 32'd0);
        @(negedge clk);
        checkOutput({tag, "/out_valid_t2"}, 32'(out_valid4), 32'd1);
        checkOutput({tag, "/diff"}, 32'(diff4), 32'(exp_diff));
        checkOutput({tag, "/borrow"}, 32'(borrow4), 32'(exp_borrow));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "/in_ready_back"}, 32'(in_ready4), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int cycles;
        int seen;

        // Reset state
        @(negedge clk);
        checkOutput("rst/out_valid", 32'(out_valid1), 32'd0);
        checkOutput("rst/busy", 32'(busy1), 32'd0);
        checkOutput("rst/diff", 32'(diff1), 32'd0);
        checkOutput("rst/borrow", 32'(borrow1), 32'd0);
        checkOutput("rst/in_ready", 32'(in_ready1), 32'd0);
        checkOutput("rst/out_valid4", 32'(out_valid4), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rel/in_ready", 32'(in_ready1), 32'd1);

        // Directed DIGIT=1 vectors
        runOp("05-03", 8'h05, 8'h03, 8'h02, 1'b0);
        runOp("03-05", 8'h03, 8'h05, 8'hFE, 1'b1);
        runOp("00-00", 8'h00, 8'h00, 8'h00, 1'b0);
        runOp("FF-01", 8'hFF, 8'h01, 8'hFE, 1'b0);
        runOp("00-01", 8'h00, 8'h01, 8'hFF, 1'b1);
        runOp("A5-5A", 8'hA5, 8'h5A, 8'h4B, 1'b0);

        // DIGIT=4 instance
        runOp4("d4_FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
        runOp4("d4_12-34", 8'h12, 8'h34, 8'hDE, 1'b1);

        // Back-pressure in DONE with ignored in_valid pulses
        applyStimulus(8'h3C, 8'h0F);
        cycles = 0;
        while (out_valid1 !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("stall/latency", 32'(cycles), 32'd8);
        for (int i = 0; i < 5; i++) begin
            a         = 8'h99;
            b         = 8'h11;
            in_valid1 = (i % 2 == 0);
            checkOutput("stall/out_valid", 32'(out_valid1), 32'd1);
            checkOutput("stall/diff", 32'(diff1), 32'h2D);
            checkOutput("stall/borrow", 32'(borrow1), 32'd0);
            checkOutput("stall/in_ready", 32'(in_ready1), 32'd0);
            @(negedge clk);
        end
        in_valid1 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("stall/out_valid_drop", 32'(out_valid1), 32'd0);
        checkOutput("stall/in_ready_back", 32'(in_ready1), 32'd1);
        @(negedge clk);
        checkOutput("stall/stays_idle", 32'(busy1), 32'd0);

        // Reset during BUSY cycle 3
        applyStimulus(8'h55, 8'h11);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort/out_valid", 32'(out_valid1), 32'd0);
        checkOutput("abort/busy", 32'(busy1), 32'd0);
        checkOutput("abort/diff", 32'(diff1), 32'd0);
        checkOutput("abort/borrow", 32'(borrow1), 32'd0);
        checkOutput("abort/in_ready", 32'(in_ready1), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid1 !== 1'b0) seen++;
        end
        checkOutput("abort/no_out_valid", 32'(seen), 32'd0);
        runOp("10-01", 8'h10, 8'h01, 8'h0F, 1'b0);

`ifdef SUB_OVERFLOW_EN
        runOp("ovf_80-01", 8'h80, 8'h01, 8'h7F, 1'b0);
        checkOutput("ovf/cleared_idle", 32'(overflow1), 32'd0);
        runOp("ovf_7F-01", 8'h7F, 8'h01, 8'h7E, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            runOp("rand", ra, rb, ra - rb, (ra < rb));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
